// File: rtl/pattern_collector.sv
// pattern_collector: gathers 4-bit results from row-interleaved solver lanes,
// buffers each lane in its own FIFO and replays them as one raster-order
// pixel stream with a valid/ready handshake. frame_done marks the end of frame.
module pattern_collector #(
  parameter int NUM_SOLVERS = 1,
  parameter int DEPTH       = 16,
  parameter int COORD_W     = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COORD_W-1:0]       frame_w,
  input  logic [COORD_W-1:0]       frame_h,
  input  logic [NUM_SOLVERS-1:0]   solver_ready,
  input  logic [4*NUM_SOLVERS-1:0] solver_out,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [3:0]               pix_data,
  output logic [COORD_W-1:0]       pix_x,
  output logic [COORD_W-1:0]       pix_y,
  output logic                     frame_done,
  output logic [NUM_SOLVERS-1:0]   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam logic [AW:0]        FULL      = (AW+1)'(DEPTH);
  localparam logic [LW-1:0]      LAST_LANE = LW'(NUM_SOLVERS - 1);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           mem    [NUM_SOLVERS][DEPTH];
  logic [AW-1:0]        wr_ptr [NUM_SOLVERS];
  logic [AW-1:0]        rd_ptr [NUM_SOLVERS];
  logic [AW:0]          count  [NUM_SOLVERS];
  logic [COORD_W-1:0]   col;
  logic [COORD_W-1:0]   row;
  logic [COORD_W-1:0]   w_lat;
  logic [COORD_W-1:0]   h_lat;
  logic [LW-1:0]        lane;
  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic [NUM_SOLVERS-1:0] push;
  logic [NUM_SOLVERS-1:0] pop;
  logic [NUM_SOLVERS-1:0] push_ok;

  assign pix_x = col;
  assign pix_y = row;

  // Handshake, head-of-FIFO fall-through and per-lane push/pop decisions.
  always_comb begin
    pix_valid = (state == RUN) && (count[lane] != (AW+1)'(0));
    pix_data  = mem[lane][rd_ptr[lane]];
    accept    = pix_valid && pix_ready && !start;
    last_col  = (col == (w_lat - ONE));
    last_row  = (row == (h_lat - ONE));
    push      = '0;
    pop       = '0;
    push_ok   = '0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      push[k]    = (state == RUN) && !start && solver_ready[k];
      pop[k]     = accept && (lane == LW'(k));
      // A full FIFO still takes a push when its head leaves in the same cycle.
      push_ok[k] = push[k] && ((count[k] != FULL) || pop[k]);
    end
  end

  // FIFO pointers, occupancy counts and sticky overflow flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_SOLVERS; k++) begin
        wr_ptr[k] <= {AW{1'b0}};
        rd_ptr[k] <= {AW{1'b0}};
        count[k]  <= {(AW+1){1'b0}};
      end
      overflow <= {NUM_SOLVERS{1'b0}};
    end else if (start) begin
      for (int k = 0; k < NUM_SOLVERS; k++) begin
        wr_ptr[k] <= {AW{1'b0}};
        rd_ptr[k] <= {AW{1'b0}};
        count[k]  <= {(AW+1){1'b0}};
      end
      overflow <= {NUM_SOLVERS{1'b0}};
    end else begin
      for (int k = 0; k < NUM_SOLVERS; k++) begin
        if (push_ok[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])     rd_ptr[k] <= rd_ptr[k] + AW'(1);
        if (push_ok[k] && !pop[k])      count[k] <= count[k] + (AW+1)'(1);
        else if (pop[k] && !push_ok[k]) count[k] <= count[k] - (AW+1)'(1);
        if (push[k] && !push_ok[k])     overflow[k] <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because counts gate every read.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      if (push_ok[k]) mem[k][wr_ptr[k]] <= solver_out[4*k +: 4];
    end
  end

  // Frame sequencer: raster counters, active lane and frame_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col        <= {COORD_W{1'b0}};
      row        <= {COORD_W{1'b0}};
      lane       <= {LW{1'b0}};
      w_lat      <= {COORD_W{1'b0}};
      h_lat      <= {COORD_W{1'b0}};
      frame_done <= 1'b0;
    end else if (start) begin
      state      <= RUN;
      col        <= {COORD_W{1'b0}};
      row        <= {COORD_W{1'b0}};
      lane       <= {LW{1'b0}};
      w_lat      <= frame_w;
      h_lat      <= frame_h;
      frame_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (last_col && last_row) begin
              // Final pixel: counters hold on the last coordinate.
              state      <= DONE;
              frame_done <= 1'b1;
            end else if (last_col) begin
              col  <= {COORD_W{1'b0}};
              row  <= row + ONE;
              lane <= (lane == LAST_LANE) ? {LW{1'b0}} : lane + LW'(1);
            end else begin
              col <= col + ONE;
            end
          end
        end
        IDLE:    state <= IDLE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
